// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OP_W-1:0] OP_SLR = 4'b0000;
   localparam logic [OP_W-1:0] OP_SLL = 4'b0001;
   localparam logic [OP_W-1:0] OP_SAR = 4'b0010;
   localparam logic [OP_W-1:0] OP_SAL = 4'b0011;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
   localparam logic [OP_W-1:0] OP_AND = 4'b0101;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
   localparam logic [OP_W-1:0] OP_NOT = 4'b0111;
   localparam logic [OP_W-1:0] OP_ADD = 4'b1000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b1001;

   // Flag bit positions inside resp_flags; C on SUB means borrow (a < b unsigned).
   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      return op <= OP_SUB;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational shared ALU: shifts by operand b, logic ops, add/sub with C/N/V/Z flags.
module alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [OP_W-1:0]   op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  result_c,
   output logic [FLAG_W-1:0] flags_c,
   output logic              illegal_c
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic           carry;
   logic           ovf;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result_c  = '0;
      carry     = 1'b0;
      ovf       = 1'b0;
      illegal_c = !op_is_legal(op);
      case (op)
         OP_SLR:         result_c = a >> b;
         OP_SLL, OP_SAL: result_c = a << b;
         OP_SAR:         result_c = WIDTH'($signed(a) >>> b);
         OP_OR:          result_c = a | b;
         OP_AND:         result_c = a & b;
         OP_XOR:         result_c = a ^ b;
         OP_NOT:         result_c = ~a;
         OP_ADD: begin
            result_c = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result_c = diff[WIDTH-1:0];
            carry    = diff[WIDTH];
            ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         default: result_c = '0;
      endcase
      flags_c         = '0;
      flags_c[FLAG_C] = carry;
      flags_c[FLAG_N] = result_c[WIDTH-1];
      flags_c[FLAG_V] = ovf;
      flags_c[FLAG_Z] = (result_c == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU; one operation in flight at a time.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [WIDTH-1:0]  resp_result,
   output logic [FLAG_W-1:0] resp_flags,
   output logic              resp_err
);

   state_e            state;
   state_e            state_nxt;
   logic              accept;
   logic              grant1;
   logic              last_id;
   logic [OP_W-1:0]   op_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              id_q;
   logic [WIDTH-1:0]  alu_result;
   logic [FLAG_W-1:0] alu_flags;
   logic              alu_illegal;

   // Next state and grant; requester 1 wins a tie only when requester 0 was granted last.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      grant1     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               grant1     = req1_valid && (!req0_valid || !last_id);
               req0_ready = !grant1;
               req1_ready = grant1;
               state_nxt  = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            if (resp_valid && resp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture on accept; the requester may change its inputs afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_id <= 1'b1;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
      end else if (accept) begin
         last_id <= grant1;
         id_q    <= grant1;
         op_q    <= grant1 ? req1_op : req0_op;
         a_q     <= grant1 ? req1_a  : req0_a;
         b_q     <= grant1 ? req1_b  : req0_b;
      end
   end

   alu_arbiter_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op        (op_q),
      .a         (a_q),
      .b         (b_q),
      .result_c  (alu_result),
      .flags_c   (alu_flags),
      .illegal_c (alu_illegal)
   );

   // Response registers load at the end of EXEC and hold until the consumer takes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid  <= 1'b0;
         resp_id     <= 1'b0;
         resp_result <= '0;
         resp_flags  <= '0;
         resp_err    <= 1'b0;
      end else if (state == ST_EXEC) begin
         resp_valid  <= 1'b1;
         resp_id     <= id_q;
         resp_result <= alu_illegal ? '0 : alu_result;
         resp_flags  <= alu_illegal ? '0 : alu_flags;
         resp_err    <= alu_illegal;
      end else if (resp_valid && resp_ready) begin
         resp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int W    = 4;
   localparam int MOD  = 1 << W;
   localparam int HALF = MOD / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         resp_valid, resp_ready, resp_id, resp_err;
   logic [W-1:0] resp_result;
   logic [3:0]   resp_flags;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU from the arithmetic definitions of each op.
   function automatic void ref_alu(input int op, input int a, input int b,
                                   output int res, output int fl, output int err);
      int sa, sb, s, d, q, c, v;
      sa = (a >= HALF) ? a - MOD : a;
      sb = (b >= HALF) ? b - MOD : b;
      c = 0; v = 0; err = 0; res = 0;
      case (op)
         0: res = (b >= W) ? 0 : a / (1 << b);
         1, 3: res = (b >= W) ? 0 : (a * (1 << b)) % MOD;
         2: begin
            d = 1 << ((b >= W) ? W : b);
            q = sa / d;
            if (sa < 0 && q * d != sa) q = q - 1;
            res = (q < 0) ? q + MOD : q;
         end
         4: res = a | b;
         5: res = a & b;
         6: res = a ^ b;
         7: res = MOD - 1 - a;
         8: begin
            res = (a + b) % MOD; c = (a + b >= MOD) ? 1 : 0;
            s = sa + sb; v = (s > HALF - 1 || s < -HALF) ? 1 : 0;
         end
         9: begin
            res = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0;
            s = sa - sb; v = (s > HALF - 1 || s < -HALF) ? 1 : 0;
         end
         default: err = 1;
      endcase
      if (err != 0) fl = 0;
      else fl = c * 8 + ((res >= HALF) ? 4 : 0) + v * 2 + ((res == 0) ? 1 : 0);
   endfunction

   // Transaction model: at most one op outstanding, response visible two cycles after accept.
   bit m_busy = 0;
   bit m_rv;
   int m_last = 1;
   int m_acc_cyc = 0;
   int cyc = 0;
   int m_id, m_res, m_fl, m_err;

   always @(negedge clk) begin
      int v0, v1, e0, e1, gid;
      v0 = int'(req0_valid);
      v1 = int'(req1_valid);
      e0 = (!m_busy && !rst && v0 == 1 && (v1 == 0 || m_last == 1)) ? 1 : 0;
      e1 = (!m_busy && !rst && v1 == 1 && (v0 == 0 || m_last == 0)) ? 1 : 0;
      m_rv = m_busy && (cyc - m_acc_cyc >= 2);
      chk("req0_ready", int'(req0_ready), e0);
      chk("req1_ready", int'(req1_ready), e1);
      chk("resp_valid", int'(resp_valid), int'(m_rv));
      if (m_rv) begin
         chk("resp_id", int'(resp_id), m_id);
         chk("resp_result", int'(resp_result), m_res);
         chk("resp_flags", int'(resp_flags), m_fl);
         chk("resp_err", int'(resp_err), m_err);
      end
      if (rst) begin
         m_busy = 0;
         m_last = 1;
      end else if (e0 == 1 || e1 == 1) begin
         gid = e1;
         if (gid == 1) ref_alu(int'(req1_op), int'(req1_a), int'(req1_b), m_res, m_fl, m_err);
         else          ref_alu(int'(req0_op), int'(req0_a), int'(req0_b), m_res, m_fl, m_err);
         m_id = gid;
         m_last = gid;
         m_busy = 1;
         m_acc_cyc = cyc;
      end else if (m_rv && resp_ready) begin
         m_busy = 0;
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input int op, input int a, input int b);
      bit got;
      got = 0;
      if (id == 0) begin
         req0_valid = 1'b1; req0_op = 4'(op); req0_a = W'(a); req0_b = W'(b);
      end else begin
         req1_valid = 1'b1; req1_op = 4'(op); req1_a = W'(a); req1_b = W'(b);
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = (id == 0) ? req0_ready : req1_ready;
         step();
      end
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      chk("send_accepted", int'(got), 1);
   endtask

   // Both requesters valid together; collect the first two responses in order.
   task automatic tie_pair(output int id0, output int res0, output int id1, output int res1,
                           output int n);
      bit r0, r1;
      id0 = -1; res0 = -1; id1 = -1; res1 = -1; n = 0;
      req0_valid = 1'b1; req0_op = 4'(OP_AND); req0_a = 4'b1100; req0_b = 4'b1010;
      req1_valid = 1'b1; req1_op = 4'(OP_OR);  req1_a = 4'b1100; req1_b = 4'b1010;
      for (int i = 0; i < 20 && n < 2; i++) begin
         @(negedge clk);
         r0 = req0_ready; r1 = req1_ready;
         step();
         if (r0) req0_valid = 1'b0;
         if (r1) req1_valid = 1'b0;
         if (resp_valid) begin
            if (n == 0) begin id0 = int'(resp_id); res0 = int'(resp_result); end
            else        begin id1 = int'(resp_id); res1 = int'(resp_result); end
            n++;
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, r0, i1, r1, n, mr, mf, me;
      bit h0, h1;
      rst = 1'b1; resp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b1; req1_op = '0; req1_a = '0; req1_b = '0;
      repeat (2) step();

      // Reset state with both requesters valid: no ready, cleared response.
      chk("rst_req0_ready", int'(req0_ready), 0);
      chk("rst_req1_ready", int'(req1_ready), 0);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_resp_id", int'(resp_id), 0);
      chk("rst_resp_result", int'(resp_result), 0);
      chk("rst_resp_flags", int'(resp_flags), 0);
      chk("rst_resp_err", int'(resp_err), 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      step();

      ref_alu(8, 7, 1, mr, mf, me);
      chk("model_add_flags", mf, 6);
      ref_alu(2, 4'b1000, 1, mr, mf, me);
      chk("model_sar", mr, 4'b1100);

      // ADD 0111+0001: two-cycle latency, overflow into negative.
      send(0, 8, 7, 1);
      chk("add_t1_valid", int'(resp_valid), 0);
      step();
      chk("add_valid", int'(resp_valid), 1);
      chk("add_id", int'(resp_id), 0);
      chk("add_result", int'(resp_result), 4'b1000);
      chk("add_flags", int'(resp_flags), 4'b0110);
      chk("add_err", int'(resp_err), 0);
      step();

      send(1, 9, 3, 3);
      step();
      chk("sub_result", int'(resp_result), 0);
      chk("sub_z", int'(resp_flags) & 1, 1);
      chk("sub_id", int'(resp_id), 1);
      step();

      send(0, 12, 5, 9);
      step();
      chk("ill_result", int'(resp_result), 0);
      chk("ill_flags", int'(resp_flags), 0);
      chk("ill_err", int'(resp_err), 1);
      step();

      // Consumer stalls five cycles while requester 0 waits.
      resp_ready = 1'b0;
      send(1, 6, 4'b1010, 4'b0110);
      step();
      req0_valid = 1'b1; req0_op = 4'(OP_ADD); req0_a = 4'd1; req0_b = 4'd1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", int'(resp_valid), 1);
         chk("hold_id", int'(resp_id), 1);
         chk("hold_result", int'(resp_result), 4'b1100);
         chk("hold_flags", int'(resp_flags), 4'b0100);
         chk("hold_ready0", int'(req0_ready), 0);
         chk("hold_ready1", int'(req1_ready), 0);
         step();
      end
      resp_ready = 1'b1;
      step();
      chk("release_valid", int'(resp_valid), 0);
      chk("release_ready0", int'(req0_ready), 1);
      step();
      req0_valid = 1'b0;
      repeat (3) step();

      rst = 1'b1; step(); rst = 1'b0;
      tie_pair(i0, r0, i1, r1, n);
      chk("tie_count", n, 2);
      chk("tie_first_id", i0, 0);
      chk("tie_first_res", r0, 4'b1000);
      chk("tie_second_id", i1, 1);
      chk("tie_second_res", r1, 4'b1110);
      step();

      // Reset during EXEC drops the op and restores the tie pointer.
      send(0, 8, 1, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("exec_rst_valid", int'(resp_valid), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("exec_rst_noresp", int'(resp_valid), 0);
      end
      tie_pair(i0, r0, i1, r1, n);
      chk("post_rst_tie_id", i0, 0);

      // Randomized traffic; requesters hold a pending request until it is accepted.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         h0 = req0_valid && req0_ready;
         h1 = req1_valid && req1_ready;
         step();
         rst = ($urandom_range(99) == 0);
         if (!req0_valid || h0) begin
            req0_valid = 1'($urandom_range(1));
            req0_op = 4'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
         end
         if (!req1_valid || h1) begin
            req1_valid = 1'($urandom_range(1));
            req1_op = 4'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
         end
         resp_ready = ($urandom_range(3) != 0);
      end
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
